gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl: RTL and testbench
===========================================================

// Module: gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl
// PURPOSE
//  Sequencer for one scan chain of sdffq cells (SE/SI/D/CLK/Q).
//  Per START: shift PATTERN in, run one capture cycle, shift the captured
//  chain state out into RESULT.
//  Sits between the test/BIST host and the chain's SE, SI and SO pins.
// PARAMETERS
//  CHAIN_LEN  16                      number of scan flops in the chain (>=2)
//  CNT_W      $clog2(CHAIN_LEN+1)     bit-counter width
// PORTS
//  CLK      in   1          chain clock; all state on posedge CLK
//  RST      in   1          synchronous, active-high reset
//  START    in   1          request a load/capture/unload run; sampled in IDLE only
//  ABORT    in   1          cancel the run in progress
//  PATTERN  in   CHAIN_LEN  stimulus; sampled when START is accepted
//  SO       in   1          Q of the last chain flop
//  SE       out  1          to every chain SE; registered
//  SI       out  1          to the first chain SI; registered
//  BUSY     out  1          high in any state other than IDLE
//  DONE     out  1          one-cycle pulse when a run completes
//  RESULT   out  CHAIN_LEN  unloaded chain state; valid from DONE until next DONE
// BEHAVIOUR
//  Reset values:
//   - SE=0, SI=0, BUSY=0, DONE=0, RESULT=0, state IDLE, counter 0.
//  FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH.
//  IDLE -> SHIFT_IN on START & !ABORT:
//   - latch PATTERN; counter=0.
//  SHIFT_IN, CHAIN_LEN cycles:
//   - SE=1, SI=PATTERN[k] in shift cycle k (k=0 first).
//   - After the last edge, the flop nearest SO holds PATTERN[0].
//  CAPTURE, 1 cycle:
//   - SE=0, SI=0; the chain captures its D inputs on the closing edge.
//  SHIFT_OUT, CHAIN_LEN cycles:
//   - SE=1, SI=0.
//   - On each edge, sample SO into RESULT[j] (j=0 first).
//   - RESULT[j] = captured value of chain flop CHAIN_LEN-1-j.
//   - RESULT is updated in place, bit by bit.
//  FINISH, 1 cycle:
//   - DONE=1, SE=0, BUSY=1; then back to IDLE.
//  Latency: START accepted at edge t -> DONE high in cycle t+2*CHAIN_LEN+2.
//   - Next START is accepted in the cycle after DONE.
//  START while BUSY: ignored, not queued.
//  ABORT in any non-IDLE state:
//   - IDLE next cycle; SE=0, SI=0, no DONE.
//   - RESULT keeps partially shifted bits.
//  ABORT and START together in IDLE: ABORT wins, stay IDLE.
//  RST mid-run: identical to power-on reset; DONE is never emitted.
//  Counter: counts 0..CHAIN_LEN-1, clears on every state change, never wraps.
//  SE/SI change only right after posedge CLK, which gives the chain full-cycle setup.
// CONFIGURATION
//  SCAN_CHAIN_CTRL_COMPARE_EN defined:
//   - adds input EXPECT[CHAIN_LEN] (sampled with PATTERN).
//   - adds output MISMATCH (1).
//   - MISMATCH = (RESULT != EXPECT), registered, valid with DONE.
//   - MISMATCH is cleared on START acceptance and on RST.
//  Macro undefined:
//   - no EXPECT/MISMATCH ports; identical cycle behaviour otherwise.
// TESTING (bench: CHAIN_LEN=8 chain of sdffq cells, D pins driven by bench)
//  1 RST held 2 cycles mid-SHIFT_IN -> SE=0, SI=0, BUSY=0, DONE=0, RESULT=0.
//  2 PATTERN=8'hA5, D=8'h00, START -> SE=1 for 8 cycles;
//    SI sequence is 1,0,1,0,0,1,0,1; DONE at t+18; RESULT=8'h00.
//  3 D=8'h3C (flop i D=bit i), START -> RESULT=8'h3C bit-reversed
//    (8'h3C); SE=0 exactly one cycle between the shift phases.
//  4 Chain state check: START with PATTERN=8'h81, ABORT asserted during
//    the CAPTURE cycle -> BUSY drops next cycle, no DONE, SE=0;
//    new START then completes normally.
//  5 START held high through the whole run -> exactly one run, one DONE;
//    second run starts the cycle after DONE; START+ABORT in IDLE -> no run.
//  6 [COMPARE_EN] EXPECT=8'h3C with D=8'h3C -> MISMATCH=0 at DONE;
//    D=8'h3D -> MISMATCH=1 at DONE, cleared on next START.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl
// Brief   : Load / capture / unload sequencer for one sdffq scan chain.
//           Optional compare: define SCAN_CHAIN_CTRL_COMPARE_EN.
// Revision: 1.0
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PATTERN,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] EXPECT,
    output logic                 MISMATCH,
`endif
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESULT
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SHIFT_OUT = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] result_q, result_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic                 mismatch_q, mismatch_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        result_d = result_q;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d = S_SHIFT_IN;
                    pat_d   = PATTERN;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                    exp_d      = EXPECT;
                    mismatch_d = 1'b0;
`endif
                end
            end
            S_SHIFT_IN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (cnt_q == C_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // bit 0 of the pattern register always feeds SI next cycle
                    pat_d = pat_q >> 1;
                end
            end
            S_CAPTURE: begin
                state_d = ABORT ? S_IDLE : S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < CHAIN_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) result_d[i] = SO;
                    end
                    if (cnt_q == C_LAST) begin
                        state_d = S_FINISH;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                        mismatch_d = (result_d != exp_q);
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        // outputs are registered from the next state so they settle right after the edge
        se_d   = (state_d == S_SHIFT_IN) || (state_d == S_SHIFT_OUT);
        si_d   = (state_d == S_SHIFT_IN) ? pat_d[0] : 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            result_q <= '0;
            se_q     <= 1'b0;
            si_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            exp_q      <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            result_q <= result_d;
            se_q     <= se_d;
            si_q     <= si_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign SE     = se_q;
    assign SI     = si_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    assign MISMATCH = mismatch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv
`default_nettype none
// Bench for the scan chain sequencer: an 8-flop sdffq chain model plus
// table-driven full runs and hand-written reset/abort/hold sequences.
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RST, START, ABORT, SO, SE, SI, BUSY, DONE;
    logic [N-1:0] PATTERN, RESULT, D;
    logic [N-1:0] chain = '0;
    logic [N-1:0] EXPECT;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic         MISMATCH;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // chain model: flop 0 takes SI, flop N-1 drives SO
    always @(posedge CLK) chain <= SE ? {chain[N-2:0], SI} : D;
    assign SO = chain[N-1];

    gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .ABORT   (ABORT),
        .PATTERN (PATTERN),
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        .EXPECT  (EXPECT),
        .MISMATCH(MISMATCH),
`endif
        .SO      (SO),
        .SE      (SE),
        .SI      (SI),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    typedef struct {
        logic [7:0] pat;
        logic [7:0] d;
        logic [7:0] exp_chain;
        logic [7:0] exp_res;
        logic [7:0] expect_v;
        logic       exp_mm;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // full run; c counts edges after the accepting edge
    task automatic run_vec(input vec_t v);
        logic [17:0] se_bits;
        logic [7:0]  si_bits;
        logic [19:0] done_bits;
        logic [19:0] busy_bits;
        PATTERN = v.pat;
        D       = v.d;
        EXPECT  = v.expect_v;
        START   = 1'b1;
        step();
        START   = 1'b0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        chk("mismatch_cleared_on_start", 32'(MISMATCH), 32'd0);
`endif
        for (int c = 0; c < 20; c++) begin
            if (c < 18) se_bits[c] = SE;
            if (c < 8)  si_bits[c] = SI;
            done_bits[c] = DONE;
            busy_bits[c] = BUSY;
            if (c == 8) chk("chain_loaded", 32'(chain), 32'(v.exp_chain));
            if (c == 17) begin
                chk("result", 32'(RESULT), 32'(v.exp_res));
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                chk("mismatch", 32'(MISMATCH), 32'(v.exp_mm));
`endif
            end
            step();
        end
        chk("si_seq", 32'(si_bits), 32'(v.pat));
        chk("se_seq", 32'(se_bits), 32'h1FEFF);
        chk("done_seq", 32'(done_bits), 32'h20000);
        chk("busy_seq", 32'(busy_bits), 32'h3FFFF);
    endtask

    int dcount;

    initial begin
        //          pat    d      chain  result expect mm
        vecs[0] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0};
        vecs[2] = '{8'h1E, 8'h0F, 8'h78, 8'hF0, 8'hF0, 1'b0};
        vecs[3] = '{8'h00, 8'h01, 8'h00, 8'h80, 8'h81, 1'b1};
        vecs[4] = '{8'hFF, 8'h80, 8'hFF, 8'h01, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'h3D, 8'h00, 8'hBC, 8'h3C, 1'b1};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0;
        PATTERN = '0; D = '0; EXPECT = '0;
        step(); step();
        RST = 1'b0;
        chk("por_se", 32'(SE), 32'd0);
        chk("por_busy", 32'(BUSY), 32'd0);
        chk("por_result", 32'(RESULT), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // reset held two cycles in the middle of SHIFT_IN
        PATTERN = 8'hFF; D = 8'hFF; START = 1'b1;
        step();
        START = 1'b0;
        step(); step();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        chk("rst_se", 32'(SE), 32'd0);
        chk("rst_si", 32'(SI), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_result", 32'(RESULT), 32'd0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            dcount += int'(DONE);
            step();
        end
        chk("rst_no_done", 32'(dcount), 32'd0);

        // START held through a run: one DONE, second run accepted after the idle cycle
        PATTERN = 8'h5A; D = 8'h00; START = 1'b1;
        step();
        dcount = 0;
        for (int c = 0; c < 19; c++) begin
            dcount += int'(DONE);
            if (c == 18) chk("hold_idle_gap", 32'(BUSY), 32'd0);
            step();
        end
        chk("hold_done_count", 32'(dcount), 32'd1);
        chk("hold_second_run", 32'(BUSY), 32'd1);
        START = 1'b0; ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_shift_in_busy", 32'(BUSY), 32'd0);
        START = 1'b1; ABORT = 1'b1;
        step();
        START = 1'b0; ABORT = 1'b0;
        chk("start_abort_idle", 32'(BUSY), 32'd0);
        step();
        chk("start_abort_still_idle", 32'(BUSY), 32'd0);

        // ABORT in the CAPTURE cycle
        PATTERN = 8'h81; D = 8'hFF; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("abort_cap_chain", 32'(chain), 32'h81);
        chk("abort_cap_se", 32'(SE), 32'd0);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_cap_busy", 32'(BUSY), 32'd0);
        chk("abort_cap_sesi", 32'({SE, SI}), 32'd0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            dcount += int'(DONE) + int'(BUSY);
            step();
        end
        chk("abort_cap_quiet", 32'(dcount), 32'd0);
        chk("abort_cap_result", 32'(RESULT), 32'h00);

        // ABORT after three unload edges keeps the partially shifted bits
        PATTERN = 8'h00; D = 8'hFF; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 0; c < 12; c++) step();
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_out_busy", 32'(BUSY), 32'd0);
        chk("abort_out_partial", 32'(RESULT & 8'hF7), 32'h07);
        step();
        chk("abort_out_no_done", 32'(DONE), 32'd0);

        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
